// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO write-side definitions: default geometry, FSM encoding and a
// small index-width helper used by the arbiter and the pointer logic.
package fifo_wr_arbiter_pkg;

  localparam int NREQ_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;
  localparam int CNT_W          = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

  // Width needed to hold a requester index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after
// last_owner (wrapping) wins; pick is one-hot, valid flags any request.
module rr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  int rank_s;
  int best_s;

  // Rank each index by its distance after last_owner and keep the closest requester.
  always_comb begin
    pick   = '0;
    valid  = 1'b0;
    rank_s = 0;
    best_s = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (i > int'(last_owner)) begin
        rank_s = i - int'(last_owner) - 1;
      end else begin
        rank_s = i + NREQ - int'(last_owner) - 1;
      end
      if (req[i] && (rank_s < best_s)) begin
        best_s  = rank_s;
        pick    = '0;
        pick[i] = 1'b1;
        valid   = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter: grants one requester at a time for a burst of up to
// MAX_BURST beats and steers its data onto the FIFO write port.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                       wclk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]            req_last,
  input  logic                       full,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic                       winc,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       busy
);

  localparam int IW = idx_width(NREQ);

  wr_state_e        state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    last_owner_q, last_owner_d;
  // Low for the first edge after reset release so no grant lands on it.
  logic             rdy_q;

  logic [NREQ-1:0]       pick_s;
  logic                  pick_vld_s;
  logic [IW-1:0]         owner_s;
  logic                  winc_s;
  logic                  last_beat_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick_s),
    .valid      (pick_vld_s)
  );

  // Owner index and data mux derived from the one-hot grant (zero when idle).
  always_comb begin
    owner_s = '0;
    wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_s = owner_s | (gnt_q[i] ? IW'(i) : IW'(0));
      wdata_s = wdata_s | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_q[i]}});
    end
  end

  assign winc_s      = (state_q == ST_BURST) & req[owner_s] & ~full;
  assign last_beat_s = winc_s & (req_last[owner_s] | (cnt_q == CNT_W'(MAX_BURST - 1)));

  assign gnt   = gnt_q;
  assign busy  = (state_q == ST_BURST);
  assign winc  = winc_s;
  assign ack   = {NREQ{winc_s}} & gnt_q;
  assign wdata = (state_q == ST_BURST) ? wdata_s : {DATA_WIDTH{1'b0}};

  // Next-state logic: grant from IDLE, count accepted beats, close the burst.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld_s && rdy_q) begin
          state_d = ST_BURST;
          gnt_d   = pick_s;
          cnt_d   = '0;
        end else begin
          gnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (last_beat_s) begin
          state_d      = ST_IDLE;
          gnt_d        = '0;
          cnt_d        = '0;
          last_owner_d = owner_s;
        end else if (winc_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any burst in flight and favours requester 0.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      cnt_q        <= '0;
      last_owner_q <= IW'(NREQ - 1);
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      rdy_q        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner
// sequences and a random phase, all against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int MB   = 4;

  logic                 wclk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic                 full;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 winc;
  logic [DW-1:0]        wdata;
  logic                 busy;

  fifo_wr_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .full     (full),
    .gnt      (gnt),
    .ack      (ack),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            winc;
    logic            busy;
    logic [DW-1:0]   wdata;
  } obs_t;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    last;
    logic               full;
    logic [NREQ*DW-1:0] data;
    obs_t               exp;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who owns the port, beats so far, previous owner.
  int m_owner;
  int m_beats;
  int m_last;
  int m_edges;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] act_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NREQ - 1;
    m_edges = 0;
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f,
                               input logic [NREQ*DW-1:0] d, input logic [NREQ-1:0] g,
                               input logic w, input logic [DW-1:0] wd);
    vec_t v;
    v.req = r; v.last = l; v.full = f; v.data = d;
    v.exp.gnt = g; v.exp.ack = w ? g : '0; v.exp.winc = w; v.exp.busy = (g != '0); v.exp.wdata = wd;
    return v;
  endfunction

  // Called just after a rising edge: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f,
                      input logic [NREQ*DW-1:0] d, output obs_t o);
    obs_t e;
    int   c;
    req = r; req_last = l; full = f; req_data = d;
    @(negedge wclk);
    o = {gnt, ack, winc, busy, wdata};
    e = '0;
    if (m_owner >= 0) begin
      e.busy  = 1'b1;
      e.gnt   = NREQ'(1) << m_owner;
      e.wdata = DW'(d >> (m_owner * DW));
      e.winc  = (((r >> m_owner) & 1) != 0) && !f;
      e.ack   = e.winc ? e.gnt : '0;
    end
    chk("model", o, e);
    if (o.winc) act_q.push_back(o.wdata);
    if (m_owner >= 0) begin
      if (e.winc) begin
        exp_q.push_back(e.wdata);
        m_beats++;
        if ((((l >> m_owner) & 1) != 0) || (m_beats == MB)) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end else if ((m_edges >= 1) && (r != '0)) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if ((m_owner < 0) && (((r >> c) & 1) != 0)) m_owner = c;
      end
      m_beats = 0;
    end
    m_edges++;
    @(posedge wclk);
    #1;
  endtask

  // Called just after a rising edge: assert reset, check outputs clear at once, release later.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out", {gnt, ack, winc, busy, wdata}, '0);
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    obs_t            o;
    vec_t            vt[0:9];
    int              order[$];
    int              beats[$];
    logic [NREQ-1:0] prev;
    int              nb;
    int              n3;
    int              nmin;
    logic            f;
    logic [NREQ-1:0] r;

    rst_n = 1'b1; req = '0; req_last = '0; full = 1'b0; req_data = '0;
    model_reset();
    @(posedge wclk);
    #1;

    // Directed table: single requester, last on beat 2, full+last, idle gap.
    req = 4'b0001;
    apply_reset();
    vt[0] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 8'h00);
    vt[1] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A1, 4'b0000, 1'b0, 8'h00);
    vt[2] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A1, 4'b0001, 1'b1, 8'hA1);
    vt[3] = mkv(4'b0001, 4'b0001, 1'b0, 32'h000000A2, 4'b0001, 1'b1, 8'hA2);
    vt[4] = mkv(4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00);
    vt[5] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A3, 4'b0000, 1'b0, 8'h00);
    vt[6] = mkv(4'b0001, 4'b0001, 1'b1, 32'h000000A4, 4'b0001, 1'b0, 8'hA4);
    vt[7] = mkv(4'b0001, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 1'b1, 8'hA5);
    vt[8] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A6, 4'b0000, 1'b0, 8'h00);
    vt[9] = mkv(4'b0001, 4'b0000, 1'b0, 32'h000000A7, 4'b0001, 1'b1, 8'hA7);
    for (int i = 0; i < 10; i++) begin
      step(vt[i].req, vt[i].last, vt[i].full, vt[i].data, o);
      chk($sformatf("vec%0d", i), o, vt[i].exp);
    end

    // All four requesting, no last: order 0,1,2,3,0 with four beats each.
    apply_reset();
    prev = '0;
    for (int i = 0; i < 28; i++) begin
      step(4'b1111, 4'b0000, 1'b0, $urandom, o);
      if ((o.gnt != '0) && (prev == '0)) begin
        order.push_back(oh2i(o.gnt));
        beats.push_back(0);
      end
      if (o.winc && (beats.size() > 0)) beats[beats.size()-1]++;
      prev = o.gnt;
    end
    chk("rr_grants", (order.size() >= 5), 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) begin
        chk($sformatf("rr_owner%0d", k), order[k], k % NREQ);
        chk($sformatf("rr_beats%0d", k), beats[k], MB);
      end
    end

    // Requester 2 with full held for three cycles after beat 1.
    apply_reset();
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      f = (i >= 3) && (i <= 5);
      step(4'b0100, 4'b0000, f, $urandom, o);
      if (o.winc) nb++;
      if (f) begin
        chk("stall_winc", o.winc, 1'b0);
        chk("stall_gnt", o.gnt, 4'b0100);
      end
    end
    chk("stall_beats", nb, 4);

    // Owner 1 drops its request for two cycles while requester 3 waits.
    apply_reset();
    n3 = 0;
    for (int i = 0; i < 10; i++) begin
      r = ((i == 3) || (i == 4)) ? 4'b1000 : 4'b1010;
      step(r, 4'b0000, 1'b0, $urandom, o);
      if (o.gnt[1] && o.ack[3]) n3++;
      if ((i == 3) || (i == 4)) chk("hold_gnt", o.gnt, 4'b0010);
    end
    chk("no_ack3", n3, 0);

    // Reset during beat 2 of requester 0, then requester 0 regains the port.
    apply_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0000, 1'b0, $urandom, o);
    #1;
    chk("pre_rst_winc", winc, 1'b1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 4'b0000, 1'b0, $urandom, o);
      if (i == 2) chk("post_rst_gnt", o.gnt, 4'b0001);
    end

    // Random traffic against the model.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = NREQ'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0,
           ($urandom_range(0, 3) == 0), $urandom, o);
    end

    // Write stream seen on the FIFO port versus beats the model accepted.
    chk("sb_len", act_q.size(), exp_q.size());
    nmin = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) chk($sformatf("sb_data%0d", i), act_q[i], exp_q[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
